// File: rtl/booth_mult_arbiter_if.sv
// Bundle of the two requester channels and the shared product response
// channel of the Booth multiplier arbiter.
interface booth_mult_arbiter_if #(
    parameter int N = 8
);
    logic           req0_valid;
    logic [N-1:0]   req0_m;
    logic [N-1:0]   req0_q;
    logic           req0_ready;

    logic           req1_valid;
    logic [N-1:0]   req1_m;
    logic [N-1:0]   req1_q;
    logic           req1_ready;

    logic           resp_valid;
    logic           resp_id;
    logic [2*N-1:0] resp_ans;
    logic           resp_ready;

    logic           busy;

    modport master (
        output req0_valid, req0_m, req0_q,
        input  req0_ready,
        output req1_valid, req1_m, req1_q,
        input  req1_ready,
        input  resp_valid, resp_id, resp_ans,
        output resp_ready,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_m, req0_q,
        output req0_ready,
        input  req1_valid, req1_m, req1_q,
        output req1_ready,
        output resp_valid, resp_id, resp_ans,
        input  resp_ready,
        output busy
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// One radix-2 Booth multiplier shared round-robin between two requesters;
// each product takes N EVAL/SHIFT pairs and is held in DONE until taken.
module booth_mult_arbiter #(
    parameter int N     = 8,
    parameter int alpha = 3
) (
    input logic                clk,
    input logic                reset,
    booth_mult_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CntW = alpha + 1;

    state_t          state_q, state_d;
    logic [N:0]      acc_q, acc_d;
    logic [N:0]      mult_q, mult_d;
    logic [N-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [CntW-1:0] count_q, count_d;
    logic            owner_q, owner_d;
    logic            lastGrant_q, lastGrant_d;
    logic            grant0, grant1;

    // Grants are masked by reset so no ready can leak out while held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || lastGrant_q);
            grant1 = bus.req1_valid && (!bus.req0_valid || !lastGrant_q);
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_id    = owner_q;
    assign bus.resp_ans   = {acc_q[N-1:0], q_q};
    assign bus.busy       = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mult_d      = mult_q;
        q_d         = q_q;
        qm1_d       = qm1_q;
        count_d     = count_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    acc_d       = '0;
                    qm1_d       = 1'b0;
                    count_d     = CntW'(N);
                    owner_d     = grant1;
                    lastGrant_d = grant1;
                    state_d     = EVAL;
                    if (grant1) begin
                        mult_d = {bus.req1_m[N-1], bus.req1_m};
                        q_d    = bus.req1_q;
                    end else begin
                        mult_d = {bus.req0_m[N-1], bus.req0_m};
                        q_d    = bus.req0_q;
                    end
                end
            end
            EVAL: begin
                case ({q_q[0], qm1_q})
                    2'b01:   acc_d = acc_q + mult_q;
                    2'b10:   acc_d = acc_q - mult_q;
                    default: acc_d = acc_q;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                {acc_d, q_d, qm1_d} = {acc_q[N], acc_q, q_q};
                count_d = count_q - CntW'(1);
                state_d = (count_q == CntW'(1)) ? DONE : EVAL;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mult_q      <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            count_q     <= '0;
            owner_q     <= 1'b0;
            lastGrant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mult_q      <= mult_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            count_q     <= count_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: hand-computed products, latency,
// round-robin tie-breaking, backpressure and reset abort.
module tb_booth_mult_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    booth_mult_arbiter_if #(.N(8)) bus ();

    booth_mult_arbiter #(.N(8), .alpha(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accept until resp_valid, bounded so a stuck DUT still ends.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.resp_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // Runs one product from a pending request through to the response being taken.
    task automatic applyStimulus(input logic expId, input logic [15:0] expAns, input bit dropAfterAccept);
        int c;
        #1;
        checkOutput("ready0_grant", bus.req0_ready, expId == 1'b0);
        checkOutput("ready1_grant", bus.req1_ready, expId == 1'b1);
        tick();
        if (dropAfterAccept) begin
            if (expId) begin
                bus.req1_valid = 1'b0;
                bus.req1_m     = 8'h5A;
                bus.req1_q     = 8'hA5;
            end else begin
                bus.req0_valid = 1'b0;
                bus.req0_m     = 8'h5A;
                bus.req0_q     = 8'hA5;
            end
        end
        checkOutput("busy_after_accept", bus.busy, 1'b1);
        checkOutput("no_ready_while_busy", bus.req0_ready | bus.req1_ready, 1'b0);
        waitDone(c);
        checkOutput("latency", c, 16);
        checkOutput("resp_id", bus.resp_id, expId);
        checkOutput("resp_ans", bus.resp_ans, expAns);
        bus.resp_ready = 1'b1;
        #1;
        checkOutput("no_accept_in_done", bus.req0_ready | bus.req1_ready, 1'b0);
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("resp_valid_dropped", bus.resp_valid, 1'b0);
        checkOutput("idle_not_busy", bus.busy, 1'b0);
    endtask

    initial begin
        int c;
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_m     = 8'h03;
        bus.req0_q     = 8'h05;
        bus.req1_valid = 1'b0;
        bus.req1_m     = 8'h00;
        bus.req1_q     = 8'h00;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready0", bus.req0_ready, 1'b0);
        checkOutput("rst_ready1", bus.req1_ready, 1'b0);
        checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("rst_resp_id", bus.resp_id, 1'b0);
        checkOutput("rst_resp_ans", bus.resp_ans, 16'h0000);
        checkOutput("rst_busy", bus.busy, 1'b0);

        reset = 1'b0;
        applyStimulus(1'b0, 16'h000F, 1'b1);

        bus.req1_m     = 8'hF9;
        bus.req1_q     = 8'h06;
        bus.req1_valid = 1'b1;
        applyStimulus(1'b1, 16'hFFD6, 1'b1);

        bus.req0_m     = 8'h80;
        bus.req0_q     = 8'h80;
        bus.req0_valid = 1'b1;
        applyStimulus(1'b0, 16'h4000, 1'b1);

        bus.req0_m     = 8'h7F;
        bus.req0_q     = 8'h80;
        bus.req0_valid = 1'b1;
        applyStimulus(1'b0, 16'hC080, 1'b1);

        // Backpressure: 5 * -3 held in DONE for ten cycles while req1 waits.
        bus.req0_m     = 8'h05;
        bus.req0_q     = 8'hFD;
        bus.req0_valid = 1'b1;
        #1;
        checkOutput("bp_ready0", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        waitDone(c);
        checkOutput("bp_latency", c, 16);
        checkOutput("bp_ans", bus.resp_ans, 16'hFFF1);
        bus.req1_m     = 8'h02;
        bus.req1_q     = 8'h03;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_hold_valid", bus.resp_valid, 1'b1);
            checkOutput("bp_hold_ans", bus.resp_ans, 16'hFFF1);
            checkOutput("bp_hold_no_ready", bus.req1_ready, 1'b0);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        checkOutput("bp_released", bus.resp_valid, 1'b0);
        applyStimulus(1'b1, 16'h0006, 1'b1);

        // Tie from reset: req0 wins first, then grants alternate.
        reset          = 1'b1;
        bus.req0_m     = 8'h02;
        bus.req0_q     = 8'h02;
        bus.req1_m     = 8'h04;
        bus.req1_q     = 8'h04;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0004, 1'b0);
        applyStimulus(1'b1, 16'h0010, 1'b0);
        applyStimulus(1'b0, 16'h0004, 1'b0);
        applyStimulus(1'b1, 16'h0010, 1'b0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // Abort: reset lands in the fifth cycle of a product.
        bus.req0_m     = 8'h33;
        bus.req0_q     = 8'h44;
        bus.req0_valid = 1'b1;
        #1;
        checkOutput("abort_ready0", bus.req0_ready, 1'b1);
        tick();
        repeat (4) tick();
        checkOutput("abort_busy_before", bus.busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_resp_valid", bus.resp_valid, 1'b0);
        checkOutput("abort_resp_ans", bus.resp_ans, 16'h0000);
        checkOutput("abort_resp_id", bus.resp_id, 1'b0);
        checkOutput("abort_ready0", bus.req0_ready, 1'b0);
        bus.req0_m = 8'h01;
        bus.req0_q = 8'hFF;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 16'hFFFF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
